// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : fifo_rd_pkg
// Purpose : Shared types and sizes for the FIFO read-side unpacker.
//           Holds the FSM state encoding, default word/beat widths and the
//           statistics counter type.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STREAM = 2'd2
  } rd_state_e;

  localparam int FIFO_DATA_W = 128;
  localparam int RD_OUT_W    = 32;

  typedef logic [31:0] stat_cnt_t;

endpackage
`default_nettype wire

// File: rtl/rd_unpack_stats.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : rd_unpack_stats
// Purpose : Delivery statistics for fifo_rd_unpacker. Counts fully delivered
//           FIFO words and output stall cycles. Both counters wrap at 2^32.
//           Present only when RD_UNPACK_STATS_EN is defined.
// Ports   : clk        - clock
//           reset      - synchronous active-low reset, clears both counters
//           valid      - output beat valid
//           ready      - sink ready
//           last       - last beat of the word
//           word_cnt   - words whose last beat was accepted
//           stall_cnt  - cycles with valid && !ready
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`ifdef RD_UNPACK_STATS_EN
module rd_unpack_stats
  import fifo_rd_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      valid,
  input  logic      ready,
  input  logic      last,
  output stat_cnt_t word_cnt,
  output stat_cnt_t stall_cnt
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      word_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (valid && ready && last)
        word_cnt <= word_cnt + 32'd1;
      if (valid && !ready)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule
`endif
`default_nettype wire

// File: rtl/fifo_rd_unpacker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : fifo_rd_unpacker
// Purpose : Pops DATA_W-bit words from a synchronous FIFO (one-cycle read
//           latency) and serialises each into OUT_W-bit valid/ready beats,
//           least-significant slice first.
// Config  : RD_UNPACK_STATS_EN - adds o_word_cnt / o_stall_cnt counters.
// Ports   : clk           - clock, all logic on posedge
//           reset         - synchronous active-low reset
//           i_fifo_empty  - FIFO empty flag
//           i_fifo_rddata - FIFO read data, valid the cycle after a read
//           o_fifo_rden   - FIFO read strobe (combinational)
//           o_valid       - output beat valid
//           i_ready       - sink ready
//           o_data        - current output beat
//           o_last        - last beat of the current word
//           o_word_cnt    - words delivered (stats build only)
//           o_stall_cnt   - stalled cycles (stats build only)
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module fifo_rd_unpacker
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int OUT_W  = RD_OUT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_fifo_empty,
  input  logic [DATA_W-1:0] i_fifo_rddata,
  output logic              o_fifo_rden,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [OUT_W-1:0]  o_data,
  output logic              o_last
`ifdef RD_UNPACK_STATS_EN
  ,
  output stat_cnt_t         o_word_cnt,
  output stat_cnt_t         o_stall_cnt
`endif
);

  localparam int BEATS  = DATA_W / OUT_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  rd_state_e                    state;
  logic [BEAT_W-1:0]            beat;
  logic [BEATS-1:0][OUT_W-1:0]  word_q;

  logic handshake;
  logic last_hs;

  assign handshake = (state == STREAM) && i_ready;
  assign last_hs   = handshake && (beat == LAST_BEAT);

  // The next pop is issued in the same cycle the final beat is accepted so
  // the only gap between words is the single read-latency bubble.
  assign o_fifo_rden = reset && !i_fifo_empty && ((state == IDLE) || last_hs);

  assign o_valid = (state == STREAM);
  assign o_data  = (state == STREAM) ? word_q[beat] : '0;
  assign o_last  = (state == STREAM) && (beat == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      beat   <= '0;
      word_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (o_fifo_rden)
            state <= WAIT;
        end
        WAIT: begin
          // FIFO read data lands here, one cycle after the strobe.
          word_q <= i_fifo_rddata;
          beat   <= '0;
          state  <= STREAM;
        end
        STREAM: begin
          if (handshake) begin
            if (beat == LAST_BEAT)
              state <= o_fifo_rden ? WAIT : IDLE;
            else
              beat <= beat + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RD_UNPACK_STATS_EN
  rd_unpack_stats u_stats (
    .clk       (clk),
    .reset     (reset),
    .valid     (o_valid),
    .ready     (i_ready),
    .last      (o_last),
    .word_cnt  (o_word_cnt),
    .stall_cnt (o_stall_cnt)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_unpacker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_fifo_rd_unpacker
// Purpose : Self-checking bench for fifo_rd_unpacker with a small FIFO model
//           that has a one-cycle registered read latency.
// Config  : RD_UNPACK_STATS_EN - also checks the statistics counters.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_fifo_rd_unpacker;

  logic         clk;
  logic         reset;
  logic         fifo_empty;
  logic [127:0] fifo_rddata;
  logic         fifo_rden;
  logic         valid;
  logic         ready;
  logic [31:0]  data;
  logic         last;
`ifdef RD_UNPACK_STATS_EN
  logic [31:0]  word_cnt;
  logic [31:0]  stall_cnt;
`endif

  fifo_rd_unpacker dut (
    .clk           (clk),
    .reset         (reset),
    .i_fifo_empty  (fifo_empty),
    .i_fifo_rddata (fifo_rddata),
    .o_fifo_rden   (fifo_rden),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_data        (data),
    .o_last        (last)
`ifdef RD_UNPACK_STATS_EN
    ,
    .o_word_cnt    (word_cnt),
    .o_stall_cnt   (stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FIFO model: registered read data, hold_empty lets the bench fake an
  // empty flag while words are still queued.
  logic [127:0] mem [0:15];
  int           wr_ptr = 0;
  int           rd_ptr = 0;
  int           bad_reads = 0;
  logic         hold_empty;

  assign fifo_empty = hold_empty || (wr_ptr == rd_ptr);

  initial fifo_rddata = '0;
  always @(posedge clk) begin
    if (fifo_rden) begin
      if (fifo_empty) bad_reads <= bad_reads + 1;
      fifo_rddata <= mem[rd_ptr[3:0]];
      rd_ptr      <= rd_ptr + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [127:0] w);
    mem[wr_ptr[3:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // Slice j of bench word k is the byte (16*k + j) repeated four times.
  function automatic logic [31:0] sl(input int k, input int j);
    logic [7:0] b;
    b = 8'(16 * k + j);
    return {b, b, b, b};
  endfunction

  function automatic logic [127:0] mkw(input int k);
    return {sl(k, 3), sl(k, 2), sl(k, 1), sl(k, 0)};
  endfunction

  typedef struct {
    logic        push;
    logic        ready;
    logic        rden;
    logic        valid;
    logic [31:0] data;
    logic        last;
  } vec_t;

  localparam logic [127:0] WORD_A = 128'h44444444_33333333_22222222_11111111;

  vec_t vecs [19];

  initial begin
    int rd_pulses, beats, last_cyc, bubbles, widx, bidx;
    bit found;

    // cycle:           push  rdy  rden vld  data          last
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0}; // pop
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0}; // read latency
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h11111111, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h22222222, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h33333333, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h44444444, 1'b1}; // FIFO now empty
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0}; // idle
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0}; // new word arrives
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h11111111, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h22222222, 1'b0}; // stall x5
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h22222222, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h22222222, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h22222222, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h22222222, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h22222222, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h33333333, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h44444444, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};

    // Reset held with a word already waiting in the FIFO.
    reset      = 1'b0;
    ready      = 1'b1;
    hold_empty = 1'b0;
    push(WORD_A);
    repeat (3) begin
      @(negedge clk);
      chk("reset_rden", 32'(fifo_rden), 32'd0);
      chk("reset_valid", 32'(valid), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b1;

    // Single word, then a word streamed under backpressure.
    for (int i = 0; i < 19; i++) begin
      if (vecs[i].push) push(WORD_A);
      ready = vecs[i].ready;
      @(negedge clk);
      chk($sformatf("vec%0d_rden", i),  32'(fifo_rden), 32'(vecs[i].rden));
      chk($sformatf("vec%0d_valid", i), 32'(valid),     32'(vecs[i].valid));
      chk($sformatf("vec%0d_data", i),  data,           vecs[i].data);
      chk($sformatf("vec%0d_last", i),  32'(last),      32'(vecs[i].last));
      @(posedge clk); #1;
    end
`ifdef RD_UNPACK_STATS_EN
    chk("stall_cnt_bp", stall_cnt, 32'd5);
    chk("word_cnt_bp",  word_cnt,  32'd2);
`endif

    // Back-to-back: three queued words, cycle 1 is the first pop.
    push(mkw(1)); push(mkw(2)); push(mkw(3));
    rd_pulses = 0; beats = 0; last_cyc = -1; bubbles = 0; widx = 0; bidx = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (fifo_rden) rd_pulses++;
      if (!valid && beats > 0 && beats < 12) bubbles++;
      if (valid && ready && widx < 3) begin
        chk($sformatf("b2b_w%0d_b%0d", widx, bidx), data, sl(widx + 1, bidx));
        beats++;
        if (widx == 2 && bidx == 3) last_cyc = c;
        if (bidx == 3) begin bidx = 0; widx++; end
        else bidx++;
      end
      @(posedge clk); #1;
    end
    chk("b2b_rden_pulses", 32'(rd_pulses), 32'd3);
    chk("b2b_beats",       32'(beats),     32'd12);
    chk("b2b_last_cycle",  32'(last_cyc),  32'd16);
    chk("b2b_bubbles",     32'(bubbles),   32'd2);
`ifdef RD_UNPACK_STATS_EN
    chk("word_cnt_b2b", word_cnt, 32'd5);
`endif

    // Reset while beat 2 of word 4 is presented; word 5 must start at beat 0.
    push(mkw(4)); push(mkw(5));
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (valid && data == sl(4, 2)) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("rst_mid_found", 32'(found), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_valid", 32'(valid), 32'd0);
    chk("rst_mid_rden",  32'(fifo_rden), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_rel_rden", 32'(fifo_rden), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk($sformatf("rst_rel_valid%0d", j), 32'(valid), 32'd1);
      chk($sformatf("rst_rel_data%0d", j), data, sl(5, j));
      @(posedge clk); #1;
    end
`ifdef RD_UNPACK_STATS_EN
    chk("word_cnt_rst",  word_cnt,  32'd1);
    chk("stall_cnt_rst", stall_cnt, 32'd0);
`endif

    // Empty flag rises in the very cycle of the last-beat handshake.
    push(mkw(6)); push(mkw(7));
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (valid && data == sl(6, 3)) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("race_found", 32'(found), 32'd1);
    hold_empty = 1'b1;
    #1;
    chk("race_last", 32'(last), 32'd1);
    chk("race_rden", 32'(fifo_rden), 32'd0);
    @(negedge clk);
    chk("race_idle_valid", 32'(valid), 32'd0);
    chk("race_idle_rden",  32'(fifo_rden), 32'd0);
    @(posedge clk); #1;
    hold_empty = 1'b0;
    #1;
    chk("race_pop_rden", 32'(fifo_rden), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("race_beat0_valid", 32'(valid), 32'd1);
    chk("race_beat0_data",  data, sl(7, 0));
    repeat (5) begin @(posedge clk); #1; end

    // Every pushed word read exactly once, never from an empty FIFO.
    chk("total_reads", 32'(rd_ptr), 32'd9);
    chk("empty_reads", 32'(bad_reads), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
